// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register.
// Contents:
//   pipe_occ_e         - occupancy state of a stage register (EMPTY/ONE/TWO)
//   PIPE_*             - default payload widths used as parameter defaults
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_occ_e;

  localparam int unsigned PIPE_CTRL_W = 32'd2;
  localparam int unsigned PIPE_ADDR_W = 32'd5;
  localparam int unsigned PIPE_DATA_W = 32'd32;
  localparam int unsigned PIPE_LANES  = 32'd2;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid flag plus control, destination address and data.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset (clears everything)
//   clr               - synchronous clear of the valid flag only; payload holds
//   load              - capture d_* (clr wins over load)
//   d_valid/ctrl/addr/data - next entry
//   q_valid/ctrl/addr/data - stored entry
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = PIPE_CTRL_W,
  parameter int unsigned ADDR_W = PIPE_ADDR_W,
  parameter int unsigned PAY_W  = PIPE_DATA_W * PIPE_LANES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              d_valid,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [PAY_W-1:0]  d_data,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [ADDR_W-1:0] q_addr,
  output logic [PAY_W-1:0]  q_data
);

  // Entry storage: reset zeroes all fields, clear only invalidates the entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_ctrl  <= {CTRL_W{1'b0}};
      q_addr  <= {ADDR_W{1'b0}};
      q_data  <= {PAY_W{1'b0}};
    end else if (clr) begin
      q_valid <= 1'b0;
    end else if (load) begin
      q_valid <= d_valid;
      q_ctrl  <= d_ctrl;
      q_addr  <= d_addr;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake,
// optional 2-entry skid buffer and synchronous flush.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   flush                 - squash every held entry (input in same cycle dropped)
//   in_valid/in_ready     - upstream handshake
//   in_ctrl/addr/data     - upstream payload, lane k at [k*DATA_W +: DATA_W]
//   out_valid/out_ready   - downstream handshake
//   out_ctrl/addr/data    - downstream payload; out_ctrl is zero on bubbles
//   occ                   - number of entries held (0..2)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = PIPE_CTRL_W,
  parameter int unsigned ADDR_W = PIPE_ADDR_W,
  parameter int unsigned DATA_W = PIPE_DATA_W,
  parameter int unsigned LANES  = PIPE_LANES,
  parameter int unsigned SKID   = 32'd1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [1:0]              occ
);

  localparam int unsigned PAY_W = LANES * DATA_W;

  pipe_occ_e         state_r;
  pipe_occ_e         next_state_s;
  logic              in_ready_r;
  logic              in_fire_s;
  logic              out_fire_s;
  logic              main_load_s;
  logic              main_clr_s;
  logic              main_from_skid_s;
  logic              skid_load_s;
  logic              skid_clr_s;

  logic              main_valid_s;
  logic [CTRL_W-1:0] main_ctrl_s;
  logic [ADDR_W-1:0] main_addr_s;
  logic [PAY_W-1:0]  main_data_s;

  logic              main_d_valid_s;
  logic [CTRL_W-1:0] main_d_ctrl_s;
  logic [ADDR_W-1:0] main_d_addr_s;
  logic [PAY_W-1:0]  main_d_data_s;

  logic              skid_valid_s;
  logic [CTRL_W-1:0] skid_ctrl_s;
  logic [ADDR_W-1:0] skid_addr_s;
  logic [PAY_W-1:0]  skid_data_s;

  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = main_valid_s & out_ready;

  // Next occupancy and storage enables; flush overrides every transition.
  always_comb begin
    next_state_s     = state_r;
    main_load_s      = 1'b0;
    main_clr_s       = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    skid_clr_s       = 1'b0;
    if (flush) begin
      next_state_s = EMPTY;
      main_clr_s   = 1'b1;
      skid_clr_s   = 1'b1;
    end else begin
      case (state_r)
        EMPTY: begin
          if (in_fire_s) begin
            next_state_s = ONE;
            main_load_s  = 1'b1;
          end else begin
            next_state_s = EMPTY;
          end
        end
        ONE: begin
          if (in_fire_s && out_fire_s) begin
            next_state_s = ONE;
            main_load_s  = 1'b1;
          end else if (out_fire_s) begin
            next_state_s = EMPTY;
            main_clr_s   = 1'b1;
          end else if (in_fire_s) begin
            // Only reachable with the skid present: simple mode gates
            // in_ready with out_ready whenever the main entry is valid.
            next_state_s = TWO;
            skid_load_s  = 1'b1;
          end else begin
            next_state_s = ONE;
          end
        end
        TWO: begin
          if (out_fire_s) begin
            next_state_s     = ONE;
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
            skid_clr_s       = 1'b1;
          end else begin
            next_state_s = TWO;
          end
        end
        default: begin
          next_state_s = EMPTY;
          main_clr_s   = 1'b1;
          skid_clr_s   = 1'b1;
        end
      endcase
    end
  end

  // Occupancy state and registered ready; ready stays low throughout reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= EMPTY;
      in_ready_r <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      in_ready_r <= (next_state_s != TWO);
    end
  end

  // The main entry refills from the skid when draining out of TWO.
  assign main_d_valid_s = main_from_skid_s ? skid_valid_s : in_valid;
  assign main_d_ctrl_s  = main_from_skid_s ? skid_ctrl_s  : in_ctrl;
  assign main_d_addr_s  = main_from_skid_s ? skid_addr_s  : in_addr;
  assign main_d_data_s  = main_from_skid_s ? skid_data_s  : in_data;

  pipe_entry_reg #(
    .CTRL_W (CTRL_W),
    .ADDR_W (ADDR_W),
    .PAY_W  (PAY_W)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (main_clr_s),
    .load    (main_load_s),
    .d_valid (main_d_valid_s),
    .d_ctrl  (main_d_ctrl_s),
    .d_addr  (main_d_addr_s),
    .d_data  (main_d_data_s),
    .q_valid (main_valid_s),
    .q_ctrl  (main_ctrl_s),
    .q_addr  (main_addr_s),
    .q_data  (main_data_s)
  );

  if (SKID != 32'd0) begin : g_skid
    pipe_entry_reg #(
      .CTRL_W (CTRL_W),
      .ADDR_W (ADDR_W),
      .PAY_W  (PAY_W)
    ) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (skid_clr_s),
      .load    (skid_load_s),
      .d_valid (in_valid),
      .d_ctrl  (in_ctrl),
      .d_addr  (in_addr),
      .d_data  (in_data),
      .q_valid (skid_valid_s),
      .q_ctrl  (skid_ctrl_s),
      .q_addr  (skid_addr_s),
      .q_data  (skid_data_s)
    );
    // Registered ready: no path from out_ready.
    assign in_ready = in_ready_r;
  end else begin : g_no_skid
    assign skid_valid_s = 1'b0;
    assign skid_ctrl_s  = {CTRL_W{1'b0}};
    assign skid_addr_s  = {ADDR_W{1'b0}};
    assign skid_data_s  = {PAY_W{1'b0}};
    // in_ready_r acts as an out-of-reset qualifier here.
    assign in_ready = in_ready_r & (~main_valid_s | out_ready);
  end

  assign out_valid = main_valid_s;
  assign out_ctrl  = main_valid_s ? main_ctrl_s : {CTRL_W{1'b0}};
  assign out_addr  = main_addr_s;
  assign out_data  = main_data_s;
  assign occ       = state_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: three instances (skid, simple, 3x16-bit lanes) share
// one stimulus stream and are each compared against a queue-based model.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [1:0]  ctrl;
    logic [4:0]  addr;
    logic [63:0] data;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  in_ctrl = 2'd0;
  logic [4:0]  in_addr = 5'd0;
  logic [63:0] in_data = 64'd0;

  logic        s_in_ready, s_out_valid, p_in_ready, p_out_valid, w_in_ready, w_out_valid;
  logic [1:0]  s_out_ctrl, p_out_ctrl, w_out_ctrl, s_occ, p_occ, w_occ;
  logic [4:0]  s_out_addr, p_out_addr, w_out_addr;
  logic [63:0] s_out_data, p_out_data;
  logic [47:0] w_out_data;

  logic        ir_a [3];
  logic        ov_a [3];
  logic [1:0]  oc_a [3];
  logic [1:0]  occ_a [3];
  logic [4:0]  oa_a [3];
  logic [63:0] od_a [3];

  entry_t mq [3][$];
  entry_t last_m [3];
  bit     rdy_m [3];
  bit     known = 1'b0;
  int     n_chk = 0;
  int     n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u_skid (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_addr(in_addr), .in_data(in_data), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_addr(s_out_addr),
    .out_data(s_out_data), .occ(s_occ)
  );

  pipe_stage_reg #(.SKID(0)) u_simple (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(p_in_ready),
    .in_ctrl(in_ctrl), .in_addr(in_addr), .in_data(in_data), .out_valid(p_out_valid),
    .out_ready(out_ready), .out_ctrl(p_out_ctrl), .out_addr(p_out_addr),
    .out_data(p_out_data), .occ(p_occ)
  );

  pipe_stage_reg #(.LANES(3), .DATA_W(16)) u_wide (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_ctrl(in_ctrl), .in_addr(in_addr), .in_data(in_data[47:0]), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_ctrl(w_out_ctrl), .out_addr(w_out_addr),
    .out_data(w_out_data), .occ(w_occ)
  );

  assign ir_a[0] = s_in_ready;  assign ir_a[1] = p_in_ready;  assign ir_a[2] = w_in_ready;
  assign ov_a[0] = s_out_valid; assign ov_a[1] = p_out_valid; assign ov_a[2] = w_out_valid;
  assign oc_a[0] = s_out_ctrl;  assign oc_a[1] = p_out_ctrl;  assign oc_a[2] = w_out_ctrl;
  assign occ_a[0] = s_occ;      assign occ_a[1] = p_occ;      assign occ_a[2] = w_occ;
  assign oa_a[0] = s_out_addr;  assign oa_a[1] = p_out_addr;  assign oa_a[2] = w_out_addr;
  assign od_a[0] = s_out_data;  assign od_a[1] = p_out_data;  assign od_a[2] = {16'd0, w_out_data};

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare every instance, advance the model.
  task automatic step(input logic rst_v, input logic fl_v, input logic iv_v,
                      input logic [1:0] c_v, input logic [4:0] a_v,
                      input logic [63:0] d_v, input logic or_v);
    bit     fire [3];
    bit     exp_rdy;
    bit     nonempty;
    entry_t head;
    entry_t e;
    @(negedge clk);
    rst_n = rst_v; flush = fl_v; in_valid = iv_v;
    in_ctrl = c_v; in_addr = a_v; in_data = d_v; out_ready = or_v;
    #1;
    for (int i = 0; i < 3; i++) begin
      nonempty = (mq[i].size() > 0);
      head = last_m[i];
      if (nonempty) head = mq[i][0];
      // Skid instances register ready; the simple one passes out_ready through.
      exp_rdy = (i == 1) ? (rdy_m[i] & (!nonempty | or_v)) : rdy_m[i];
      fire[i] = iv_v & exp_rdy;
      if (known) begin
        check_value($sformatf("u%0d.in_ready", i), {63'd0, ir_a[i]}, {63'd0, exp_rdy});
        check_value($sformatf("u%0d.out_valid", i), {63'd0, ov_a[i]}, {63'd0, nonempty});
        check_value($sformatf("u%0d.occ", i), {62'd0, occ_a[i]}, 64'(mq[i].size()));
        check_value($sformatf("u%0d.out_ctrl", i), {62'd0, oc_a[i]},
                    nonempty ? {62'd0, head.ctrl} : 64'd0);
        check_value($sformatf("u%0d.out_addr", i), {59'd0, oa_a[i]}, {59'd0, head.addr});
        check_value($sformatf("u%0d.out_data", i), od_a[i], head.data);
      end
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      e.ctrl = c_v;
      e.addr = a_v;
      e.data = (i == 2) ? {16'd0, d_v[47:0]} : d_v;
      if (!rst_v) begin
        mq[i].delete();
        last_m[i] = '0;
        rdy_m[i] = 1'b0;
      end else if (fl_v) begin
        mq[i].delete();
        rdy_m[i] = 1'b1;
      end else begin
        if (mq[i].size() > 0 && or_v) void'(mq[i].pop_front());
        if (fire[i]) mq[i].push_back(e);
        if (mq[i].size() > 0) last_m[i] = mq[i][0];
        rdy_m[i] = (mq[i].size() < 2);
      end
    end
    if (!rst_v) known = 1'b1;
    #1;
  endtask

  initial begin
    // Reset held three cycles with a valid input pending.
    repeat (3) step(1'b0, 1'b0, 1'b1, 2'b11, 5'd3, 64'h0000_1234_5678_9ABC, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 64'd0, 1'b1);

    // Back-to-back stream with out_ready held high.
    step(1'b1, 1'b0, 1'b1, 2'b11, 5'd7, 64'hDEAD_BEEF_0000_0010, 1'b1);
    for (int k = 1; k < 5; k++)
      step(1'b1, 1'b0, 1'b1, 2'(k), 5'(k + 8), {32'(k) * 32'h0101_0101, 32'h1000_0000 + 32'(k)}, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 64'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 64'd0, 1'b1);

    // Back-pressure: A, B, C pushed while out_ready is low, C re-presented.
    step(1'b1, 1'b0, 1'b1, 2'b01, 5'd10, 64'hAAAA_0000_AAAA_0001, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2'b10, 5'd11, 64'hBBBB_0000_BBBB_0002, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2'b11, 5'd12, 64'hCCCC_0000_CCCC_0003, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2'b11, 5'd12, 64'hCCCC_0000_CCCC_0003, 1'b1);
    step(1'b1, 1'b0, 1'b1, 2'b11, 5'd12, 64'hCCCC_0000_CCCC_0003, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 64'd0, 1'b1);

    // Fill to two entries, then flush together with a valid input D.
    step(1'b1, 1'b0, 1'b1, 2'b01, 5'd20, 64'h1111_2222_3333_4444, 1'b0);
    step(1'b1, 1'b0, 1'b1, 2'b10, 5'd21, 64'h5555_6666_7777_8888, 1'b0);
    step(1'b1, 1'b1, 1'b1, 2'b11, 5'd22, 64'hDDDD_DDDD_DDDD_DDDD, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 64'd0, 1'b1);

    // Third lane of the 16-bit instance must arrive untouched.
    step(1'b1, 1'b0, 1'b1, 2'b01, 5'd5, 64'h0000_A5A5_1234_5678, 1'b1);
    check_value("wide.lane2", {48'd0, w_out_data[47:32]}, 64'h0000_0000_0000_A5A5);
    check_value("wide.valid", {63'd0, w_out_valid}, 64'd1);
    step(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 64'd0, 1'b1);

    // Randomised traffic with occasional flush and reset.
    for (int k = 0; k < 600; k++)
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0), 2'($urandom), 5'($urandom),
           {$urandom, $urandom}, ($urandom_range(0, 3) != 0));
    step(1'b1, 1'b0, 1'b0, 2'b00, 5'd0, 64'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
